// File: rtl/or_pool_accumulator.sv
// Pools GROUP_LEN serial pixel bits into one thresholded bit plus its set-bit count.
// A one-deep output register with valid/ready on both sides gives one pixel per cycle.
module or_pool_accumulator #(
  parameter int GROUP_LEN = 5,
  parameter int CNT_W     = 3,
  parameter int THRESHOLD = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             In_Bit,
  input  logic             In_Last,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Out_Bit,
  output logic [CNT_W-1:0] Out_Count,
  output logic             Out_Last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GROUP_LEN - 1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(THRESHOLD);

  function automatic logic pool_bit(input logic [CNT_W-1:0] count);
    return count >= THRESH;
  endfunction

  logic [CNT_W-1:0] idx_p0;
  logic [CNT_W-1:0] ones_p0;
  logic [CNT_W-1:0] sum_p0;
  logic             acc_p0;
  logic             done_p0;

  logic             vld_p1;
  logic             bit_p1;
  logic             last_p1;
  logic [CNT_W-1:0] count_p1;

  assign In_Ready = ~Reset & (~vld_p1 | Out_Ready);
  assign acc_p0   = In_Valid & In_Ready;
  assign done_p0  = acc_p0 & ((idx_p0 == LAST_IDX) | In_Last);
  assign sum_p0   = ones_p0 + {{(CNT_W-1){1'b0}}, In_Bit};

  // Stage p0: group accumulation (pixel index and running ones count)
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_p0  <= '0;
      ones_p0 <= '0;
    end else if (done_p0) begin
      idx_p0  <= '0;
      ones_p0 <= '0;
    end else if (acc_p0) begin
      idx_p0  <= idx_p0 + 1'b1;
      ones_p0 <= sum_p0;
    end
  end

  // Stage p1: output register; a completion reloads it even while it is being drained
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p1   <= 1'b0;
      bit_p1   <= 1'b0;
      count_p1 <= '0;
      last_p1  <= 1'b0;
    end else if (done_p0) begin
      vld_p1   <= 1'b1;
      bit_p1   <= pool_bit(sum_p0);
      count_p1 <= sum_p0;
      last_p1  <= In_Last;
    end else if (vld_p1 && Out_Ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign Out_Valid = vld_p1;
  assign Out_Bit   = bit_p1;
  assign Out_Count = count_p1;
  assign Out_Last  = last_p1;

endmodule

// File: tb/tb_or_pool_accumulator.sv
// Bench for or_pool_accumulator: two instances (THRESHOLD 1 and 3) share one stimulus
// stream and are compared every cycle against a queue-based group model.
module tb_or_pool_accumulator;

  localparam int GL = 5;
  localparam int CW = 3;

  logic Clock = 1'b0;
  logic Reset, In_Valid, In_Bit, In_Last, Out_Ready;

  logic          rdy1, vld1, bit1, last1;
  logic [CW-1:0] cnt1;
  logic          rdy3, vld3, bit3, last3;
  logic [CW-1:0] cnt3;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  or_pool_accumulator #(.GROUP_LEN(GL), .CNT_W(CW), .THRESHOLD(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(rdy1),
    .In_Bit(In_Bit), .In_Last(In_Last), .Out_Valid(vld1), .Out_Ready(Out_Ready),
    .Out_Bit(bit1), .Out_Count(cnt1), .Out_Last(last1));

  or_pool_accumulator #(.GROUP_LEN(GL), .CNT_W(CW), .THRESHOLD(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(rdy3),
    .In_Bit(In_Bit), .In_Last(In_Last), .Out_Valid(vld3), .Out_Ready(Out_Ready),
    .Out_Bit(bit3), .Out_Count(cnt3), .Out_Last(last3));

  // Reference model: pixels of the open group, and the pending result
  bit   grp[$];
  bit   m_vld = 1'b0;
  int   m_cnt = 0;
  bit   m_last = 1'b0;
  bit   m_rst = 1'b0;
  bit   exp_rdy;
  int   results = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input logic b, input logic l,
                     input logic ordy);
    int sum;
    @(negedge Clock);
    Reset = rst; In_Valid = v; In_Bit = b; In_Last = l; Out_Ready = ordy;
    #1;
    exp_rdy = !rst && (!m_vld || ordy);
    chk("in_ready_t1", {7'd0, rdy1}, {7'd0, exp_rdy});
    chk("in_ready_t3", {7'd0, rdy3}, {7'd0, exp_rdy});
    @(posedge Clock);
    if (rst) begin
      grp.delete();
      m_vld = 0; m_cnt = 0; m_last = 0; m_rst = 1;
    end else begin
      if (m_vld && ordy) m_vld = 0;
      if (v && exp_rdy) begin
        grp.push_back(b);
        if (grp.size() == GL || l) begin
          sum = 0;
          foreach (grp[i]) sum += grp[i];
          grp.delete();
          m_vld = 1; m_cnt = sum; m_last = l; m_rst = 0;
          results++;
        end
      end
    end
    #1;
    chk("out_valid_t1", {7'd0, vld1}, {7'd0, m_vld});
    chk("out_valid_t3", {7'd0, vld3}, {7'd0, m_vld});
    if (m_vld || m_rst) begin
      chk("out_count_t1", {5'd0, cnt1}, 8'(m_cnt));
      chk("out_count_t3", {5'd0, cnt3}, 8'(m_cnt));
      chk("out_bit_t1", {7'd0, bit1}, {7'd0, m_cnt >= 1});
      chk("out_bit_t3", {7'd0, bit3}, {7'd0, m_cnt >= 3});
      chk("out_last_t1", {7'd0, last1}, {7'd0, m_last});
      chk("out_last_t3", {7'd0, last3}, {7'd0, m_last});
    end
  endtask

  task automatic send(input logic [4:0] bits, input int n, input logic last_on_end);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, bits[i], last_on_end && (i == n - 1), 1'b1);
  endtask

  initial begin
    Reset = 1; In_Valid = 0; In_Bit = 0; In_Last = 0; Out_Ready = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    // Single group 0,0,1,0,0 (bit i of the vector is pixel i)
    send(5'b00100, 5, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t1_result_count", 8'(results), 8'd1);
    // All-zero group followed back-to-back by all-one group
    send(5'b00000, 5, 0);
    send(5'b11111, 5, 0);
    cyc(0, 0, 0, 0, 1);
    // Short frame 1,0,1 then a fresh group
    send(5'b00101, 3, 1);
    send(5'b10001, 5, 0);
    cyc(0, 0, 0, 0, 1);
    // Backpressure: result stalled for 10 cycles with input pending
    send(5'b01011, 5, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0);
    send(5'b11000, 5, 1);
    cyc(0, 0, 0, 0, 1);
    // Reset mid-group discards the partial group
    send(5'b00111, 3, 0);
    cyc(1, 1, 1, 0, 1);
    send(5'b10000, 5, 0);
    cyc(0, 0, 0, 0, 1);
    // Threshold-3 boundary groups
    send(5'b00011, 5, 0);
    send(5'b00111, 5, 0);
    // One-pixel frames and last-on-final-pixel
    send(5'b00001, 1, 1);
    send(5'b00000, 1, 1);
    send(5'b10110, 5, 1);
    cyc(0, 0, 0, 0, 1);
    // Randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
